// File: rtl/switch_word_loader.sv
// switch_word_loader: builds a WORD_W-bit word one byte at a time from the
// eight data switches and offers it downstream over a valid/ready handshake.
// Optional macro SWITCH_WORD_LOADER_DEBOUNCE_EN compiles in per-key
// debouncers; without it, the synchronized key levels are used directly.
// Key index map: 0 = commit, 1 = back, 2 = send.

module switch_word_loader #(
  parameter int unsigned WORD_W          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  localparam int unsigned NBytes         = WORD_W / 8,
  localparam int unsigned IdxW           = (NBytes > 1) ? $clog2(NBytes) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_sw,
  input  logic              i_key_commit,
  input  logic              i_key_back,
  input  logic              i_key_send,
  output logic [IdxW-1:0]   o_byte_idx,
  output logic [7:0]        o_byte_led,
  output logic [WORD_W-1:0] o_word,
  output logic              o_out_valid,
  input  logic              i_out_ready
);

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NBytes - 1);

  logic [2:0]        w_key_raw;
  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [1:0]        r_live;
  logic [2:0]        r_arm;
  logic [2:0]        w_press;
  logic [WORD_W-1:0] r_word;
  logic [IdxW-1:0]   r_idx;
  logic              r_valid;

  assign w_key_raw = {i_key_send, i_key_back, i_key_commit};

  // Two-flop synchronizers plus press arming. A key only arms once it has been
  // seen released after reset, so a key held through reset never fires.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_live  <= '0;
      r_arm   <= '0;
    end else begin
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
      // r_live[1] marks when r_sync2 reflects real key levels, not reset values
      r_live  <= {r_live[0], 1'b1};
      r_arm   <= r_arm | ({3{r_live[1]}} & r_sync2);
    end
  end

`ifdef SWITCH_WORD_LOADER_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] r_cnt [3];
  logic [2:0]      r_db;
  logic [2:0]      r_press;

  // Per-key debouncer: the level flips after DEBOUNCE_CYCLES consecutive
  // mismatching cycles; a registered one-cycle pulse marks each press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_db    <= '1;
      r_press <= '0;
      for (int k = 0; k < 3; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        r_press[k] <= 1'b0;
        if (r_sync2[k] == r_db[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CntLast) begin
          r_cnt[k]   <= '0;
          r_db[k]    <= r_sync2[k];
          r_press[k] <= r_db[k] & r_arm[k];
        end else begin
          r_cnt[k] <= r_cnt[k] + CntW'(1);
        end
      end
    end
  end

  assign w_press = r_press;
`else
  logic [2:0] r_sync_q;

  // Previous synchronized level, used to detect the falling (press) edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_q <= '1;
    end else begin
      r_sync_q <= r_sync2;
    end
  end

  assign w_press = r_sync_q & ~r_sync2 & r_arm;
`endif

  // Word assembly and handshake; transfer > send > commit > back.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (r_valid) begin
      // Word and index frozen while offered; key pulses are dropped.
      if (i_out_ready) begin
        r_valid <= 1'b0;
        r_idx   <= '0;
      end
    end else if (w_press[2]) begin
      r_valid <= 1'b1;
    end else if (w_press[0]) begin
      r_word[r_idx*8 +: 8] <= i_sw;
      r_idx                <= (r_idx == IdxLast) ? '0 : r_idx + IdxW'(1);
    end else if (w_press[1]) begin
      r_idx <= (r_idx == '0) ? IdxLast : r_idx - IdxW'(1);
    end
  end

  assign o_byte_idx  = r_idx;
  assign o_byte_led  = r_word[r_idx*8 +: 8];
  assign o_word      = r_word;
  assign o_out_valid = r_valid;

endmodule

// File: doc/switch_word_loader.md
# switch_word_loader

Parametrised successor to the board's switch-to-instruction input register. It assembles a WORD_W-bit word one byte at a time from the 8 data switches, stepping the byte position with debounced pushbuttons. It then hands the finished word to the CPU, or any downstream consumer, over a valid/ready handshake. It sits between the board switches/keys and the CPU `in` port and drives the LEDR byte readback.

## Interface
Parameters:
- WORD_W, 16, assembled word width; must be a multiple of 8 and ≥16. NBYTES = WORD_W/8.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a key level change; must be ≥2.

Ports:
- clk  in  1  single clock for all state.
- reset  in  1  asynchronous, active-low reset.
- sw  in  8  byte value to write (board SW[7:0]).
- key_commit  in  1  raw pushbutton, 1 when released; press writes sw into the current byte and advances.
- key_back  in  1  raw pushbutton, 1 when released; press steps the byte index back.
- key_send  in  1  raw pushbutton, 1 when released; press offers the word downstream.
- byte_idx  out  $clog2(NBYTES) (min 1)  current byte position; 0 = bits [7:0].
- byte_led  out  8  stored byte at byte_idx, i.e. word[byte_idx*8 +: 8]; combinational.
- word  out  WORD_W  assembled word register.
- out_valid  out  1  word is offered downstream.
- out_ready  in  1  downstream accepts; a transfer occurs on any edge where out_valid && out_ready.

## Operation
- **Key conditioning:**
  - Each key passes through a 2-flop synchronizer and then a debouncer.
  - Debouncer state resets to released (1).
  - The per-key counter clears on any cycle where the synchronized level equals the debounced state.
  - The debounced state flips when the counter reaches DEBOUNCE_CYCLES.
  - A one-cycle press pulse is generated on the debounced 1→0 transition.
  - Releases generate nothing.
- **Commit pulse:**
  - Applies only if out_valid=0.
  - Writes word[byte_idx*8 +: 8] ← sw.
  - Sets byte_idx ← byte_idx+1, wrapping from NBYTES-1 to 0.
- **Back pulse:** applies only if out_valid=0; sets byte_idx ← byte_idx-1, wrapping from 0 to NBYTES-1.
- **Send pulse:** if out_valid=0, set out_valid←1; otherwise ignored.
- **While out_valid=1:**
  - word and byte_idx are frozen.
  - Commit and back pulses are dropped, not queued.
- **Transfer** (out_valid && out_ready at an edge):
  - out_valid←0 and byte_idx←0.
  - word retains its value, so partial edits start from the last word.
- **Same-cycle priority:** transfer > send > commit > back; lower-priority pulses in the same cycle are dropped.
  - Send+commit in one cycle: the send wins and the commit byte is lost.
  - Transfer and send pulse in one cycle: the transfer completes, the send is ignored, and out_valid=0 afterwards.
- **out_ready while out_valid=0:** no effect.
- **Reset values (asynchronous, immediate):** word=0, byte_idx=0, out_valid=0, byte_led=0, all sync flops=1, debounced states=1, counters=0.
- **Reset asserted mid-debounce or mid-handshake:** the in-progress press or offer is discarded; no pulse on deassertion even if the key is held.

## Timing
- Let edge k be the first clk edge sampling a key low, with the key held low throughout.
- With debounce: the key's effect is registered on edge k+DEBOUNCE_CYCLES+2 and visible on outputs after that edge.
- Without debounce: the effect is registered on edge k+2.
- A key low for fewer than DEBOUNCE_CYCLES synchronized cycles produces no pulse.
- A held key produces exactly one pulse.
- out_valid rises on the same edge as the send effect and falls on the transfer edge.
- Minimum offer duration is 1 cycle if out_ready is already high.
- The output side has no combinational path from out_ready to out_valid.

## Configuration
- Macro SWITCH_WORD_LOADER_DEBOUNCE_EN.
- **Defined:** the debouncers above are compiled in and DEBOUNCE_CYCLES applies.
- **Undefined:**
  - Debouncers and counters are removed; the debounced state equals the synchronizer output.
  - The press pulse is the 1→0 transition of the synchronizer output.
  - DEBOUNCE_CYCLES is ignored.
  - Used for simulation and for keys already debounced on the board.

## Test plan
Bench parameters: WORD_W=32, DEBOUNCE_CYCLES=4 unless noted.
1. **Reset defaults:** reset low mid-run with word=0xDEADBEEF → word=0, byte_idx=0, out_valid=0 immediately without a clock edge.
2. **Assemble and transfer:**
   - Stimulus: commit sw=0x11,0x22,0x33,0x44, each key held 10 cycles, then send with out_ready=0 for 5 cycles, then 1.
   - Required: word=0x44332211; byte_idx wraps to 0 after the 4th commit; out_valid high 5+1 cycles then 0.
   - Commit during out_valid leaves word unchanged.
3. **Bounce rejection and latency:**
   - A key_commit low glitch of 3 cycles → no change.
   - Low held from edge k → byte_idx changes exactly at edge k+6.
   - Held 100 cycles → one increment only.
4. **Back wrap and readback:** from byte_idx=0, back → byte_idx=3 and byte_led=word[31:24]; commit sw=0xAB → word[31:24]=0xAB, byte_idx=0.
5. **Simultaneous events:**
   - Commit and send pulses on the same edge → out_valid=1, word unchanged.
   - Send pulse while out_valid=1 and out_ready=1 → out_valid=0 next, byte_idx=0.
6. **Macro undefined:** key low from edge k → effect at edge k+2; a 1-cycle glitch lasting ≥1 sampled cycle produces one pulse.
